// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - serial byte-stream loader for the instruction RAM
//
// Receives a framed program image from the UART receiver and writes it into
// the instruction RAM as big-endian 32-bit words. It holds the CPU in reset
// while loading and reports the outcome.
//
// Frame: LEN_HI, LEN_LO (word count N), N*4 payload bytes (MSB first),
//        CHK = XOR of all payload bytes.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   start         one-cycle pulse, begins a load (only in IDLE/DONE/ERR)
//   rx_data       received byte
//   rx_valid      one-cycle strobe qualifying rx_data
//   wr_en         instruction RAM write strobe, one cycle per word
//   wr_addr       word address of the write
//   wr_data       word to write
//   cpu_hold      keeps the CPU in reset while high
//   done          image loaded and checksum matched
//   error         load aborted (bad length, bad checksum or timeout)
//   words_loaded  words written in the current or last load
module imem_loader #(
   parameter int MEM_WORDS      = 160,
   parameter int ADDR_W         = 8,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state;
   logic [7:0]        len_hi;
   logic [ADDR_W:0]   n_words;
   logic [23:0]       word_sr;     // first three bytes of the word in progress
   logic [1:0]        byte_idx;
   logic [7:0]        acc;         // running XOR of payload bytes
   logic [ADDR_W-1:0] word_idx;
   logic [TMO_W-1:0]  tmo_cnt;

   logic [15:0]       len_full;
   logic              len_bad;
   logic              loading;
   logic              last_word;

   assign len_full  = {len_hi, rx_data};
   assign len_bad   = (len_full == 16'd0) || (len_full > 16'(MEM_WORDS));
   assign loading   = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                      (state == S_DATA)   || (state == S_CHECK);
   // word_idx is still the index of the word being completed here
   assign last_word = ((ADDR_W+1)'(word_idx) + CNT_ONE) == n_words;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         len_hi       <= '0;
         n_words      <= '0;
         word_sr      <= '0;
         byte_idx     <= '0;
         acc          <= '0;
         word_idx     <= '0;
         tmo_cnt      <= '0;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         cpu_hold     <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= '0;
      end else begin
         wr_en <= 1'b0;

         // The count follows the write strobe so it advances once the
         // word has actually been presented to the RAM.
         if (wr_en) begin
            words_loaded <= words_loaded + CNT_ONE;
         end

         // Inter-byte idle watchdog while a frame is in progress.
         if (loading) begin
            if (rx_valid) begin
               tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_LAST) begin
               state <= S_ERR;
               error <= 1'b1;
            end else begin
               tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
         end

         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state        <= S_LEN_HI;
                  cpu_hold     <= 1'b1;
                  done         <= 1'b0;
                  error        <= 1'b0;
                  words_loaded <= '0;
                  acc          <= '0;
                  wr_addr      <= '0;
                  word_idx     <= '0;
                  byte_idx     <= '0;
                  tmo_cnt      <= '0;
               end
            end

            S_LEN_HI: begin
               if (rx_valid) begin
                  len_hi <= rx_data;
                  state  <= S_LEN_LO;
               end
            end

            S_LEN_LO: begin
               if (rx_valid) begin
                  if (len_bad) begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end else begin
                     n_words <= len_full[ADDR_W:0];
                     state   <= S_DATA;
                  end
               end
            end

            S_DATA: begin
               if (rx_valid) begin
                  word_sr  <= {word_sr[15:0], rx_data};
                  acc      <= acc ^ rx_data;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     wr_en    <= 1'b1;
                     wr_addr  <= word_idx;
                     wr_data  <= {word_sr, rx_data};
                     word_idx <= word_idx + IDX_ONE;
                     // Move on immediately so a back-to-back CHK byte
                     // in the write cycle is not lost.
                     if (last_word) begin
                        state <= S_CHECK;
                     end
                  end
               end
            end

            S_CHECK: begin
               if (rx_valid) begin
                  if (rx_data == acc) begin
                     state    <= S_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     // cpu_hold stays high: never run a corrupt image
                     state <= S_ERR;
                     error <= 1'b1;
                  end
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

   localparam int MEM_WORDS = 160;
   localparam int ADDR_W    = 8;
   localparam int TMO       = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              cpu_hold;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   words_loaded;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   imem_loader #(
      .MEM_WORDS      (MEM_WORDS),
      .ADDR_W         (ADDR_W),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   // write monitor, sampled on the falling edge
   int          got_addr[$];
   logic [31:0] got_data[$];
   int          dbl_pulses = 0;
   logic        wr_en_prev = 1'b0;

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         got_addr.push_back(int'(wr_addr));
         got_data.push_back(wr_data);
         if (wr_en_prev) dbl_pulses++;
      end
      wr_en_prev = (wr_en === 1'b1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference model: derive the outcome of a byte sequence from the frame rules
   byte unsigned frame[$];
   int           exp_addr[$];
   logic [31:0]  exp_data[$];
   logic         exp_done;
   logic         exp_err;
   int           exp_wl;

   task automatic model();
      int n, avail, full;
      logic [7:0] chk;
      exp_addr.delete();
      exp_data.delete();
      exp_done = 1'b0;
      exp_err  = 1'b1;        // anything short of a good CHK ends in error
      exp_wl   = 0;
      if (frame.size() < 2) return;
      n = int'(frame[0]) * 256 + int'(frame[1]);
      if (n == 0 || n > MEM_WORDS) return;
      avail = (frame.size() - 2) / 4;
      full  = (avail < n) ? avail : n;
      for (int w = 0; w < full; w++) begin
         exp_addr.push_back(w);
         exp_data.push_back({frame[2+4*w], frame[3+4*w], frame[4+4*w], frame[5+4*w]});
      end
      exp_wl = full;
      if (frame.size() >= 3 + 4 * n) begin
         chk = 8'h00;
         for (int i = 0; i < 4 * n; i++) chk ^= frame[2+i];
         exp_done = (frame[2+4*n] == chk);
         exp_err  = !exp_done;
      end
   endtask

   task automatic build_frame(input int n, input bit corrupt);
      logic [7:0] chk;
      logic [15:0] len;
      len = 16'(n);
      frame.delete();
      frame.push_back(len[15:8]);
      frame.push_back(len[7:0]);
      chk = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
         frame.push_back(8'($urandom_range(0, 255)));
         chk ^= frame[frame.size()-1];
      end
      if (corrupt) chk ^= 8'($urandom_range(1, 255));
      frame.push_back(chk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drive_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic run_frame(input string name, input int gap_max, input int start_at);
      int nmin;
      got_addr.delete();
      got_data.delete();
      dbl_pulses = 0;
      model();
      pulse_start();
      for (int i = 0; i < frame.size(); i++) begin
         if (i == start_at) start = 1'b1;
         drive_byte(frame[i]);
         start = 1'b0;
         repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
      repeat (TMO + 4) @(negedge clk);
      check({name, " wr_count"}, got_addr.size(), exp_addr.size());
      nmin = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
      for (int i = 0; i < nmin; i++) begin
         check($sformatf("%s wr_addr[%0d]", name, i), got_addr[i], exp_addr[i]);
         check($sformatf("%s wr_data[%0d]", name, i), got_data[i], exp_data[i]);
      end
      check({name, " done"}, done, exp_done);
      check({name, " error"}, error, exp_err);
      check({name, " cpu_hold"}, cpu_hold, !exp_done);
      check({name, " words_loaded"}, words_loaded, exp_wl);
      check({name, " single_pulse"}, dbl_pulses, 0);
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check("rst wr_en", wr_en, 0);
      check("rst wr_addr", wr_addr, 0);
      check("rst wr_data", wr_data, 0);
      check("rst cpu_hold", cpu_hold, 0);
      check("rst done", done, 0);
      check("rst error", error, 0);
      check("rst words_loaded", words_loaded, 0);
      reset = 1'b0;
      @(negedge clk);

      // rx bursts in IDLE are ignored
      got_addr.delete();
      for (int i = 0; i < 12; i++) drive_byte(i < 2 ? 8'h00 : 8'($urandom_range(0, 255)));
      repeat (3) @(negedge clk);
      check("idle writes", got_addr.size(), 0);
      check("idle cpu_hold", cpu_hold, 0);
      check("idle done", done, 0);
      check("idle error", error, 0);

      // known good 3-word image, back to back
      frame = {8'h00, 8'h03, 8'h08, 8'h00, 8'h00, 8'h03, 8'h3C, 8'h10,
               8'h40, 8'h00, 8'h24, 8'h08, 8'hF8, 8'h00, 8'hB3};
      run_frame("good3", 0, -1);
      check("good3 word2", got_data.size() == 3 ? got_data[2] : 32'h0, 32'h2408F800);

      // same image, bad checksum, then recovery
      frame[14] = 8'hB2;
      run_frame("badchk", 0, -1);
      frame[14] = 8'hB3;
      run_frame("recover", 0, -1);

      // length boundaries
      frame = {8'h00, 8'h00};
      run_frame("len0", 0, -1);
      frame = {8'h00, 8'hA1};
      run_frame("len161", 0, -1);
      build_frame(MEM_WORDS, 1'b0);
      run_frame("len160", 0, -1);
      check("len160 last_addr",
            got_addr.size() > 0 ? got_addr[got_addr.size()-1] : 0, MEM_WORDS - 1);

      // start pulsed in DATA has no effect
      build_frame(3, 1'b0);
      run_frame("start_in_data", 1, 5);

      // timeout exactly TMO cycles after the last byte
      got_addr.delete();
      pulse_start();
      drive_byte(8'h00);
      drive_byte(8'h03);
      drive_byte(8'h08);
      repeat (TMO - 1) @(negedge clk);
      check("tmo early error", error, 0);
      @(negedge clk);
      check("tmo error", error, 1);
      check("tmo cpu_hold", cpu_hold, 1);
      check("tmo writes", got_addr.size(), 0);

      // reset after two complete words of a 3-word load
      build_frame(3, 1'b0);
      got_addr.delete();
      pulse_start();
      for (int i = 0; i < 10; i++) drive_byte(frame[i]);
      @(negedge clk);
      check("rstmid writes", got_addr.size(), 2);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rstmid wr_en", wr_en, 0);
      check("rstmid wr_addr", wr_addr, 0);
      check("rstmid wr_data", wr_data, 0);
      check("rstmid cpu_hold", cpu_hold, 0);
      check("rstmid done", done, 0);
      check("rstmid error", error, 0);
      check("rstmid words_loaded", words_loaded, 0);
      for (int i = 10; i < frame.size(); i++) drive_byte(frame[i]);
      repeat (4) @(negedge clk);
      check("rstmid no_more_writes", got_addr.size(), 2);
      check("rstmid idle hold", cpu_hold, 0);

      // randomized frames against the model
      for (int t = 0; t < 24; t++) begin
         int kind;
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            frame = {8'h00, 8'h00};
         end else if (kind == 1) begin
            frame = {8'($urandom_range(1, 255)), 8'($urandom_range(0, 255))};
         end else begin
            build_frame($urandom_range(1, 6), $urandom_range(0, 3) == 0);
            if (kind == 2) begin
               repeat ($urandom_range(1, frame.size() - 1)) void'(frame.pop_back());
            end
         end
         run_frame($sformatf("rand%0d", t), $urandom_range(0, 1) ? 0 : 3, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
